// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-port read arbiter in front of a single in-order memory port. Requests
// from port 0 and port 1 are arbitrated onto the shared memory request
// channel. Each accepted memory request records the granted port id in a tag
// FIFO. Because the memory answers in request order, the head of that FIFO
// routes each returning response back to the port that issued it.
//
// Build option:
//   MEM_ARBITER_FIXED_PRIO_EN  defined   -> port 0 always wins a tie
//                              undefined -> round-robin between the ports
//
// Ports:
//   clk               sole clock, rising edge
//   rst               asynchronous reset, active low (0 = reset)
//   pN_req_addr       requester N read address            (N = 0, 1)
//   pN_req_valid      requester N request valid
//   pN_req_ready      requester N request accepted this cycle
//   pN_resp_data      response data to requester N
//   pN_resp_valid     response valid to requester N
//   pN_resp_ready     requester N can take the response
//   mem_req_addr      shared memory request address
//   mem_req_valid     shared memory request valid
//   mem_req_ready     memory accepts the request
//   mem_resp_data     memory response data
//   mem_resp_valid    memory response valid
//   mem_resp_ready    arbiter accepts the memory response
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    output logic [DATA_WIDTH-1:0] p0_resp_data,
    output logic                  p0_resp_valid,
    input  logic                  p0_resp_ready,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    output logic [DATA_WIDTH-1:0] p1_resp_data,
    output logic                  p1_resp_valid,
    input  logic                  p1_resp_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_lockPort;
    logic              w_nextLockPort;

    logic              r_tagFifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_pick;
    logic              w_sel;
    logic              w_selValid;
    logic              w_memReqValid;
    logic              w_push;
    logic              w_pop;
    logic              w_head;
    logic              w_respActive;

`ifndef MEM_ARBITER_FIXED_PRIO_EN
    logic              r_lastGnt;
`endif

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Idle-state winner. With only one requester it wins outright; on a tie
    // the fixed build favours port 0, the round-robin build favours whichever
    // port was not granted last.
    always_comb begin
        w_pick = 1'b0;
`ifdef MEM_ARBITER_FIXED_PRIO_EN
        w_pick = p0_req_valid ? 1'b0 : 1'b1;
`else
        if (p0_req_valid && p1_req_valid) begin
            w_pick = ~r_lastGnt;
        end else begin
            w_pick = p0_req_valid ? 1'b0 : 1'b1;
        end
`endif
    end

    // Once a request is stalled by the memory the address must not change,
    // so the locked port owns the channel until its handshake completes.
    assign w_sel      = (r_state == LOCKED) ? r_lockPort : w_pick;
    assign w_selValid = w_sel ? p1_req_valid : p0_req_valid;

    // A full tag FIFO blocks new grants even if a pop happens this cycle.
    assign w_memReqValid = rst && !w_full && w_selValid;
    assign w_push        = w_memReqValid && mem_req_ready;

    assign mem_req_valid = w_memReqValid;
    assign mem_req_addr  = w_sel ? p1_req_addr : p0_req_addr;
    assign p0_req_ready  = w_push && !w_sel;
    assign p1_req_ready  = w_push &&  w_sel;

    always_comb begin
        w_nextState    = r_state;
        w_nextLockPort = r_lockPort;
        case (r_state)
            IDLE: begin
                if (w_memReqValid && !mem_req_ready) begin
                    w_nextState    = LOCKED;
                    w_nextLockPort = w_pick;
                end
            end
            LOCKED: begin
                if (w_push) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_lockPort <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_lockPort <= w_nextLockPort;
        end
    end

`ifndef MEM_ARBITER_FIXED_PRIO_EN
    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lastGnt <= 1'b1;
        end else if (w_push) begin
            r_lastGnt <= w_sel;
        end
    end
`endif

    // Response routing follows the oldest outstanding tag. With nothing
    // outstanding, any response from the memory is refused.
    assign w_head       = r_tagFifo[r_rdPtr];
    assign w_respActive = rst && !w_empty;

    assign p0_resp_valid  = w_respActive && !w_head && mem_resp_valid;
    assign p1_resp_valid  = w_respActive &&  w_head && mem_resp_valid;
    assign mem_resp_ready = w_respActive && (w_head ? p1_resp_ready : p0_resp_ready);
    assign p0_resp_data   = mem_resp_data;
    assign p1_resp_data   = mem_resp_data;

    assign w_pop = mem_resp_valid && mem_resp_ready;

    // Tag FIFO. The depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_tagFifo[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_tagFifo[r_wrPtr] <= w_sel;
                r_wrPtr            <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. The bench plays both requesters and the
// memory. Every grant the bench expects pushes the expected port onto a
// scoreboard queue; every memory response it returns pops that queue to
// determine which port must see the data.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] p0ReqAddr = '0;
    logic        p0ReqValid = 1'b0;
    logic        p0ReqReady;
    logic [31:0] p0RespData;
    logic        p0RespValid;
    logic        p0RespReady = 1'b0;
    logic [31:0] p1ReqAddr = '0;
    logic        p1ReqValid = 1'b0;
    logic        p1ReqReady;
    logic [31:0] p1RespData;
    logic        p1RespValid;
    logic        p1RespReady = 1'b0;
    logic [31:0] memReqAddr;
    logic        memReqValid;
    logic        memReqReady = 1'b0;
    logic [31:0] memRespData = '0;
    logic        memRespValid = 1'b0;
    logic        memRespReady;

    int   testsRun  = 0;
    int   failCount = 0;
    logic sbQ [$];

    mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .p0_req_addr    (p0ReqAddr),
        .p0_req_valid   (p0ReqValid),
        .p0_req_ready   (p0ReqReady),
        .p0_resp_data   (p0RespData),
        .p0_resp_valid  (p0RespValid),
        .p0_resp_ready  (p0RespReady),
        .p1_req_addr    (p1ReqAddr),
        .p1_req_valid   (p1ReqValid),
        .p1_req_ready   (p1ReqReady),
        .p1_resp_data   (p1RespData),
        .p1_resp_valid  (p1RespValid),
        .p1_resp_ready  (p1RespReady),
        .mem_req_addr   (memReqAddr),
        .mem_req_valid  (memReqValid),
        .mem_req_ready  (memReqReady),
        .mem_resp_data  (memRespData),
        .mem_resp_valid (memRespValid),
        .mem_resp_ready (memRespReady)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks happen later
    // in the same cycle, well away from either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0,
                                 input logic v1, input logic [31:0] a1,
                                 input logic memReady);
        p0ReqValid  = v0;
        p0ReqAddr   = a0;
        p1ReqValid  = v1;
        p1ReqAddr   = a1;
        memReqReady = memReady;
    endtask

    // Check one grant cycle: the expected port sees ready and owns the address.
    task automatic checkGrant(input string tag, input logic expPort,
                              input logic [31:0] expAddr);
        #1;
        checkOutput({tag, "_p0rdy"}, 32'(p0ReqReady), 32'(!expPort));
        checkOutput({tag, "_p1rdy"}, 32'(p1ReqReady), 32'(expPort));
        checkOutput({tag, "_addr"}, memReqAddr, expAddr);
        sbQ.push_back(expPort);
        tick();
    endtask

    // Return one memory response and verify it lands on the scoreboard port.
    task automatic deliverResp(input string tag, input logic [31:0] data);
        logic expPort;
        memRespValid = 1'b1;
        memRespData  = data;
        p0RespReady  = 1'b1;
        p1RespReady  = 1'b1;
        #1;
        if (sbQ.size() == 0) begin
            testsRun++;
            failCount++;
            $error("[TB] FAIL %s: scoreboard empty, observed resp data 0x%0h, expected none", tag, data);
        end else begin
            expPort = sbQ.pop_front();
            checkOutput({tag, "_v0"}, 32'(p0RespValid), 32'(!expPort));
            checkOutput({tag, "_v1"}, 32'(p1RespValid), 32'(expPort));
            checkOutput({tag, "_data"}, expPort ? p1RespData : p0RespData, data);
            checkOutput({tag, "_mrdy"}, 32'(memRespReady), 32'd1);
        end
        tick();
        memRespValid = 1'b0;
        p0RespReady  = 1'b0;
        p1RespReady  = 1'b0;
    endtask

    initial begin
        logic expPort;

        // Reset held with live-looking inputs: every valid/ready must be low.
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h20, 1'b1);
        memRespValid = 1'b1;
        p0RespReady  = 1'b1;
        p1RespReady  = 1'b1;
        #1;
        checkOutput("rst_mvalid", 32'(memReqValid), 32'd0);
        checkOutput("rst_p0rdy", 32'(p0ReqReady), 32'd0);
        checkOutput("rst_p1rdy", 32'(p1ReqReady), 32'd0);
        checkOutput("rst_mrdy", 32'(memRespReady), 32'd0);
        checkOutput("rst_p0v", 32'(p0RespValid), 32'd0);
        checkOutput("rst_p1v", 32'(p1RespValid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        memRespValid = 1'b0;
        p0RespReady  = 1'b0;
        p1RespReady  = 1'b0;
        tick();
        rst = 1'b1;

        // Both ports request every cycle: round-robin alternates starting at
        // port 0, fixed priority always picks port 0. Fourth grant fills FIFO.
        applyStimulus(1'b1, 32'h10, 1'b1, 32'h20, 1'b1);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_FIXED_PRIO_EN
            expPort = 1'b0;
`else
            expPort = (i % 2 == 1);
`endif
            checkGrant($sformatf("rr%0d", i), expPort, expPort ? 32'h20 : 32'h10);
        end
        #1;
        checkOutput("rr_full_mvalid", 32'(memReqValid), 32'd0);
        checkOutput("rr_full_p0rdy", 32'(p0ReqReady), 32'd0);
        checkOutput("rr_full_p1rdy", 32'(p1ReqReady), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            deliverResp($sformatf("rr_resp%0d", i), 32'h11 + 32'(i));
        end

        // Four requests p0,p1,p1,p0 with no responses; fifth is blocked.
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        checkGrant("ord0", 1'b0, 32'h40);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h41, 1'b1);
        checkGrant("ord1", 1'b1, 32'h41);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h42, 1'b1);
        checkGrant("ord2", 1'b1, 32'h42);
        applyStimulus(1'b1, 32'h43, 1'b0, 32'h0, 1'b1);
        checkGrant("ord3", 1'b0, 32'h43);
        applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("ord_blk_mvalid", 32'(memReqValid), 32'd0);
        checkOutput("ord_blk_p0rdy", 32'(p0ReqReady), 32'd0);

        // Full FIFO: a pop and a pending request in the same cycle. The pop
        // must not open the way for the request until the following cycle.
        memRespValid = 1'b1;
        memRespData  = 32'hA;
        p0RespReady  = 1'b1;
        p1RespReady  = 1'b1;
        #1;
        checkOutput("pp_p0rdy", 32'(p0ReqReady), 32'd0);
        checkOutput("pp_mvalid", 32'(memReqValid), 32'd0);
        expPort = sbQ.pop_front();
        checkOutput("pp_resp_v0", 32'(p0RespValid), 32'(!expPort));
        checkOutput("pp_resp_data", p0RespData, 32'hA);
        checkOutput("pp_mrdy", 32'(memRespReady), 32'd1);
        tick();
        memRespValid = 1'b0;
        p0RespReady  = 1'b0;
        p1RespReady  = 1'b0;
        checkGrant("pp_next", 1'b0, 32'h44);
        applyStimulus(1'b1, 32'h45, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("pp_still_full", 32'(memReqValid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        deliverResp("ord_resp_b", 32'hB);
        deliverResp("ord_resp_c", 32'hC);
        deliverResp("ord_resp_d", 32'hD);
        deliverResp("ord_resp_e", 32'hE);

        // Spurious response with nothing outstanding is refused.
        memRespValid = 1'b1;
        memRespData  = 32'hDEAD;
        p0RespReady  = 1'b1;
        p1RespReady  = 1'b1;
        #1;
        checkOutput("spur_mrdy", 32'(memRespReady), 32'd0);
        checkOutput("spur_p0v", 32'(p0RespValid), 32'd0);
        checkOutput("spur_p1v", 32'(p1RespValid), 32'd0);
        tick();
        memRespValid = 1'b0;

        // Response backpressure from port 0 holds the memory response.
        applyStimulus(1'b1, 32'h50, 1'b0, 32'h0, 1'b1);
        checkGrant("bp_req", 1'b0, 32'h50);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        memRespValid = 1'b1;
        memRespData  = 32'h5A;
        p0RespReady  = 1'b0;
        p1RespReady  = 1'b1;
        #1;
        checkOutput("bp_mrdy_lo", 32'(memRespReady), 32'd0);
        checkOutput("bp_p0v", 32'(p0RespValid), 32'd1);
        tick();
        #1;
        checkOutput("bp_mrdy_lo2", 32'(memRespReady), 32'd0);
        tick();
        deliverResp("bp_resp", 32'h5A);

        // Lock: p1 stalls at 0x100 for three cycles; p0 arrives meanwhile but
        // must wait until p1 completes its handshake.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        #1;
        checkOutput("lk_c1_addr", memReqAddr, 32'h100);
        checkOutput("lk_c1_mvalid", 32'(memReqValid), 32'd1);
        tick();
        applyStimulus(1'b1, 32'h200, 1'b1, 32'h100, 1'b0);
        #1;
        checkOutput("lk_c2_addr", memReqAddr, 32'h100);
        tick();
        #1;
        checkOutput("lk_c3_addr", memReqAddr, 32'h100);
        checkOutput("lk_c3_p0rdy", 32'(p0ReqReady), 32'd0);
        tick();
        applyStimulus(1'b1, 32'h200, 1'b1, 32'h100, 1'b1);
        checkGrant("lk_c4", 1'b1, 32'h100);
        applyStimulus(1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        checkGrant("lk_c5", 1'b0, 32'h200);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        deliverResp("lk_resp0", 32'h61);
        deliverResp("lk_resp1", 32'h62);

        // Asynchronous reset with two requests outstanding.
        applyStimulus(1'b1, 32'h70, 1'b0, 32'h0, 1'b1);
        checkGrant("ar_req0", 1'b0, 32'h70);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h71, 1'b1);
        checkGrant("ar_req1", 1'b1, 32'h71);
        applyStimulus(1'b1, 32'h72, 1'b0, 32'h0, 1'b1);
        memRespValid = 1'b1;
        memRespData  = 32'h77;
        p0RespReady  = 1'b1;
        p1RespReady  = 1'b1;
        #1;
        checkOutput("ar_pre_mrdy", 32'(memRespReady), 32'd1);
        checkOutput("ar_pre_mvalid", 32'(memReqValid), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("ar_mvalid", 32'(memReqValid), 32'd0);
        checkOutput("ar_p0rdy", 32'(p0ReqReady), 32'd0);
        checkOutput("ar_mrdy", 32'(memRespReady), 32'd0);
        checkOutput("ar_p0v", 32'(p0RespValid), 32'd0);
        sbQ.delete();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("ar_post_mrdy", 32'(memRespReady), 32'd0);
        checkOutput("ar_post_p0v", 32'(p0RespValid), 32'd0);
        checkOutput("ar_post_p1v", 32'(p1RespValid), 32'd0);
        memRespValid = 1'b0;
        tick();
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
        checkGrant("ar_new", 1'b0, 32'h80);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        deliverResp("ar_new_resp", 32'h88);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, memory response data width.
REQ-003 Parameter MAX_OUTSTANDING, default 4, tag-FIFO depth (power of two, >=2).
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert by source.
REQ-006 pN_req_addr  in  ADDR_WIDTH  requester N (N=0,1) read address.
REQ-007 pN_req_valid  in  1  requester N request valid.
REQ-008 pN_req_ready  out  1  requester N request accepted this cycle.
REQ-009 pN_resp_data  out  DATA_WIDTH  response data to requester N.
REQ-010 pN_resp_valid  out  1  response valid to requester N.
REQ-011 pN_resp_ready  in  1  requester N can take response.
REQ-012 mem_req_addr  out  ADDR_WIDTH  shared memory request address.
REQ-013 mem_req_valid  out  1  shared memory request valid.
REQ-014 mem_req_ready  in  1  memory accepts request.
REQ-015 mem_resp_data  in  DATA_WIDTH  memory response data.
REQ-016 mem_resp_valid  in  1  memory response valid.
REQ-017 mem_resp_ready  out  1  arbiter accepts memory response.

Function
REQ-018 Memory returns responses in request order; arbiter SHALL push granted port id into tag FIFO on every mem_req_valid&&mem_req_ready.
REQ-019 New grant only when FIFO count < MAX_OUTSTANDING; at full, mem_req_valid=0, both pN_req_ready=0 (no push/pop bypass).
REQ-020 Arbitration states IDLE/LOCKED: IDLE picks winner combinationally; if mem_req_valid && !mem_req_ready, enter LOCKED holding winner until handshake, then IDLE.
REQ-021 In LOCKED, mem_req_addr/valid SHALL track locked port only; other port waits even if valid.
REQ-022 Round-robin: single requester wins; both valid -> port not last granted wins; last-granted pointer updates on handshake only.
REQ-023 pN_req_ready = (port N is winner) && mem_req_ready && FIFO not full; combinational, zero added latency.
REQ-024 Response routing: FIFO head selects port; pHead_resp_valid=mem_resp_valid, pHead_resp_data=mem_resp_data, mem_resp_ready=pHead_resp_ready; other port resp_valid=0.
REQ-025 FIFO empty -> mem_resp_ready=0, both pN_resp_valid=0 (spurious response not accepted).
REQ-026 Pop on mem_resp_valid&&mem_resp_ready; simultaneous push and pop SHALL leave count unchanged and be legal at any count incl. full (pop does not enable push that cycle).
REQ-027 Count width clog2(MAX_OUTSTANDING)+1; read/write pointers wrap modulo MAX_OUTSTANDING.
REQ-028 pN_resp_data SHALL equal mem_resp_data for both ports (valid gates use).

Reset
REQ-029 On rst=0: FIFO count 0, pointers 0, state IDLE, last-granted = port 1 (port 0 wins first tie).
REQ-030 During reset all valid/ready outputs 0; reset mid-transaction discards outstanding tags, later responses not accepted until new request issued.

Configuration
REQ-031 Macro MEM_ARBITER_FIXED_PRIO_EN: defined -> port 0 always wins ties, last-granted pointer removed; undefined -> round-robin per REQ-022. LOCKED behaviour identical in both.

Verification
REQ-032 Both ports valid every cycle, mem_req_ready=1, round-robin -> grants alternate 0,1,0,1; with FIXED_PRIO_EN -> port 0 only.
REQ-033 p1 valid addr 0x100, mem_req_ready=0 for 3 cycles, p0 raises valid cycle 2 -> mem_req_addr stays 0x100, p1 granted cycle 4, then p0.
REQ-034 Issue 4 requests (p0,p1,p1,p0), no responses -> 5th blocked (mem_req_valid=0); return data 0xA,0xB,0xC,0xD -> delivered to p0,p1,p1,p0 in order.
REQ-035 Full FIFO, same cycle response pop and pending request -> request not granted that cycle, granted next cycle, count stays 4.
REQ-036 mem_resp_valid=1 with empty FIFO -> mem_resp_ready=0, no pN_resp_valid; p0_resp_ready=0 with head=p0 -> mem_resp_ready=0 until raised.
REQ-037 rst=0 asynchronously with 2 outstanding -> outputs 0 immediately, count 0 after release.
